// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and widths for the SDRAM port arbiter
package sdram_arb_pkg;
  localparam int ADDR_W = 24;
  localparam int LEN_W  = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - loadable up-counter with clear, enable and terminal flag
module arb_watchdog #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term_val,
  output logic         term
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            count <= '0;
    else if (clr)          count <= '0;
    else if (load)         count <= load_val;
    else if (en && !term)  count <= count + 1'b1;
  end

  assign term = (count >= term_val);
endmodule

// File: rtl/sdram_port_arb.sv
// rtl/sdram_port_arb.sv - arbitrates display reads and loader writes onto one SDRAM command port
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int RD_BURST      = 256,
  parameter int WR_BURST      = 256,
  parameter int MAX_RD_STREAK = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_grant,
  output logic              wr_done,
  output logic              sdr_req,
  output logic              sdr_wr,
  output logic [ADDR_W-1:0] sdr_addr,
  output logic [LEN_W-1:0]  sdr_len,
  input  logic              sdr_ack,
  input  logic              sdr_done,
  output logic              arb_err
);
  localparam int         WD_W       = $clog2(TIMEOUT + 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_RD_STREAK);

  arb_state_t state;
  logic [3:0] streak;
  logic       rd_v, pick_rd, pick_wr, ack_take, wd_term;

  assign rd_v     = rd_req & disp_en;
  assign pick_rd  = rd_v && (!wr_req || streak < STREAK_MAX);
  assign pick_wr  = !pick_rd && wr_req;
  assign ack_take = (state == ST_ISSUE) && sdr_req && sdr_ack;

  // Loading 1 on the ack edge makes the count equal to cycles elapsed since ack,
  // so the error appears exactly TIMEOUT cycles after the ack cycle.
  arb_watchdog #(.W(WD_W)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == ST_IDLE),
    .load     (ack_take),
    .load_val (WD_W'(1)),
    .en       (state == ST_BUSY),
    .term_val (WD_W'(TIMEOUT - 1)),
    .term     (wd_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      streak   <= '0;
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      sdr_req  <= 1'b0;
      sdr_wr   <= 1'b0;
      sdr_addr <= '0;
      sdr_len  <= '0;
      arb_err  <= 1'b0;
    end else begin
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!wr_req) streak <= '0;
          if (pick_rd) begin
            rd_grant <= 1'b1;
            sdr_addr <= rd_addr;
            sdr_wr   <= 1'b0;
            sdr_len  <= LEN_W'(RD_BURST);
            state    <= ST_ISSUE;
            if (wr_req && streak != 4'hF) streak <= streak + 4'd1;
          end else if (pick_wr) begin
            wr_grant <= 1'b1;
            sdr_addr <= wr_addr;
            sdr_wr   <= 1'b1;
            sdr_len  <= LEN_W'(WR_BURST);
            streak   <= '0;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!sdr_req) begin
            sdr_req <= 1'b1;
          end else if (sdr_ack) begin
            sdr_req <= 1'b0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (sdr_done || wd_term) begin
            rd_done <= !sdr_wr;
            wr_done <= sdr_wr;
            if (!sdr_done) arb_err <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arb.sv
// tb/tb_sdram_port_arb.sv - self-checking bench for sdram_port_arb
module tb_sdram_port_arb;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_en, rd_req, wr_req, sdr_ack, sdr_done;
  logic [23:0] rd_addr, wr_addr;
  logic        rd_grant, rd_done, wr_grant, wr_done, sdr_req, sdr_wr, arb_err;
  logic [23:0] sdr_addr;
  logic [9:0]  sdr_len;

  int checks   = 0;
  int failures = 0;
  int m_streak = 0;

  sdram_port_arb #(
    .RD_BURST(256), .WR_BURST(256), .MAX_RD_STREAK(MAXS), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_grant(wr_grant), .wr_done(wr_done),
    .sdr_req(sdr_req), .sdr_wr(sdr_wr), .sdr_addr(sdr_addr), .sdr_len(sdr_len),
    .sdr_ack(sdr_ack), .sdr_done(sdr_done), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 1 = read wins, 2 = write wins, 0 = nothing granted
  function automatic int model_pick(bit r, bit w, bit de);
    if (r && de && (!w || m_streak < MAXS)) return 1;
    if (w) return 2;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; rd_req = 0; wr_req = 0; disp_en = 0; sdr_ack = 0; sdr_done = 0;
    rd_addr = '0; wr_addr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_streak = 0;
    @(negedge clk);
  endtask

  // One request/grant/command/done transaction; done_d < 0 leaves the burst hanging.
  task automatic run_round(input bit r, input bit w, input bit de,
                           input logic [23:0] ra, input logic [23:0] wa,
                           input int ack_d, input int done_d, output int kind);
    int exp_kind, lat;
    exp_kind = model_pick(r, w, de);
    rd_req = r; wr_req = w; disp_en = de; rd_addr = ra; wr_addr = wa;
    kind = 0; lat = 0;
    while (kind == 0 && lat < 8) begin
      @(negedge clk); lat++;
      if (rd_grant) kind = 1; else if (wr_grant) kind = 2;
    end
    chk("grant_kind", kind, exp_kind);
    chk("grant_latency", lat, 1);
    if (kind == 0) begin rd_req = 0; wr_req = 0; return; end
    if (exp_kind == 2) m_streak = 0;
    else if (w) m_streak = (m_streak < 15) ? m_streak + 1 : 15;
    else m_streak = 0;
    rd_req = 0; wr_req = 0;
    chk("sdr_req_at_grant", sdr_req, 0);
    @(negedge clk);
    chk("grant_one_pulse", {rd_grant, wr_grant}, 0);
    chk("sdr_req", sdr_req, 1);
    chk("sdr_wr", sdr_wr, kind == 2);
    chk("sdr_addr", sdr_addr, (kind == 2) ? wa : ra);
    chk("sdr_len", sdr_len, 256);
    repeat (ack_d) @(negedge clk);
    sdr_ack = 1; @(negedge clk); sdr_ack = 0;
    chk("sdr_req_drop", sdr_req, 0);
    if (done_d < 0) return;
    repeat (done_d - 1) @(negedge clk);
    chk("no_early_done", {rd_done, wr_done}, 0);
    sdr_done = 1; @(negedge clk); sdr_done = 0;
    chk("rd_done", rd_done, kind == 1);
    chk("wr_done", wr_done, kind == 2);
  endtask

  initial begin
    int k;
    int exp_seq1[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int exp_seq2[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
    bit r, w, de;

    // Reset state
    rst_n = 0; rd_req = 0; wr_req = 0; disp_en = 0; sdr_ack = 0; sdr_done = 0;
    rd_addr = '0; wr_addr = '0;
    #12;
    chk("reset_outputs", {rd_grant, rd_done, wr_grant, wr_done, sdr_req, sdr_wr,
                          sdr_addr, sdr_len, arb_err}, 0);

    // Write-only burst
    do_reset();
    run_round(0, 1, 0, 24'h000000, 24'h0C0000, 2, 20, k);
    chk("wr_only_kind", k, 2);

    // Both requesters held: bounded read streak
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_round(1, 1, 1, 24'($urandom), 24'($urandom), $urandom % 3, 1 + $urandom % 4, k);
      chk("streak_seq", k, exp_seq1[i]);
    end

    // Read gating by disp_en
    do_reset();
    rd_req = 1; disp_en = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("gated_idle", {rd_grant, wr_grant, sdr_req}, 0);
    end
    run_round(1, 0, 1, 24'h0ABCDE, 24'h0, 0, 3, k);
    chk("ungated_kind", k, 1);

    // Hung controller: watchdog
    do_reset();
    run_round(0, 1, 0, 24'h0, 24'h0C0100, 1, -1, k);
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      if (c == 99) begin
        chk("err_before_timeout", arb_err, 0);
        chk("done_before_timeout", wr_done, 0);
      end
    end
    chk("err_at_timeout", arb_err, 1);
    chk("done_at_timeout", {rd_done, wr_done}, 2'b01);
    run_round(1, 0, 1, 24'h000400, 24'h0, 0, 2, k);
    chk("served_after_timeout", k, 1);
    chk("err_sticky", arb_err, 1);

    // Async reset while BUSY
    run_round(0, 1, 0, 24'h0, 24'h123456, 0, -1, k);
    repeat (3) @(negedge clk);
    #1 rst_n = 0;
    #1 chk("async_reset_outputs", {rd_grant, rd_done, wr_grant, wr_done, sdr_req, sdr_wr,
                                   sdr_addr, sdr_len, arb_err}, 0);
    @(negedge clk);
    rst_n = 1; m_streak = 0;
    sdr_done = 1; @(negedge clk); sdr_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {rd_done, wr_done, sdr_req, arb_err}, 0);
    end
    run_round(1, 1, 1, 24'h000800, 24'h0C0800, 1, 2, k);
    chk("after_reset_kind", k, 1);

    // Writer withdraws before it would win: streak clears
    do_reset();
    for (int i = 0; i < 10; i++) begin
      w = (i != 4);
      run_round(1, w, 1, 24'($urandom), 24'($urandom), $urandom % 2, 1 + $urandom % 3, k);
      chk("wr_drop_seq", k, exp_seq2[i]);
    end

    // Randomised traffic against the reference model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom); w = 1'($urandom); de = 1'($urandom);
      if (!(r && de) && !w) w = 1;
      run_round(r, w, de, 24'($urandom), 24'($urandom), $urandom % 4, 1 + $urandom % 8, k);
    end
    chk("random_no_err", arb_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
